axis_fifo_reader: RTL

//  Read-side adapter: drains a native (non-FWFT) FIFO, 1-cycle read latency, onto an AXI-stream master.

---
 rtl/axis_skid2.sv | 61 ++++++
 rtl/axis_fifo_reader.sv | 95 +++++++++
 2 files changed

// File: rtl/axis_skid2.sv
// -----------------------------------------------------------------------------
// axis_skid2: two-entry head/skid output buffer.
// The head slot drives the output; the skid slot absorbs a word that lands while
// the head is held by a stalled consumer. The writer must never present more
// words than the buffer has room for (the caller tracks credit), so no input
// ready is exposed.
// Ports:
//   clk, sync_reset        clock, synchronous active-high reset
//   in_valid, in_data      word to store this cycle
//   out_valid, out_data    head entry (registered)
//   out_ready              consumer accepts the head this cycle
// -----------------------------------------------------------------------------
module axis_skid2 #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  sync_reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready
);

   logic                  head_valid;
   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] head_data;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  pop_c;

   assign pop_c = head_valid & out_ready;

   // Head/skid update; the skid entry is always older than an incoming word.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         head_valid <= 1'b0;
         skid_valid <= 1'b0;
         head_data  <= '0;
         skid_data  <= '0;
      end else if (pop_c) begin
         if (skid_valid) begin
            head_data  <= skid_data;
            skid_valid <= in_valid;
            if (in_valid) skid_data <= in_data;
         end else begin
            head_valid <= in_valid;
            if (in_valid) head_data <= in_data;
         end
      end else if (!head_valid) begin
         head_valid <= in_valid;
         if (in_valid) head_data <= in_data;
      end else if (in_valid) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

   assign out_valid = head_valid;
   assign out_data  = head_data;

endmodule

// File: rtl/axis_fifo_reader.sv
// -----------------------------------------------------------------------------
// axis_fifo_reader: drains a native (1-cycle read latency) FIFO onto an
// AXI-stream master, inserting tlast every frame_len+1 beats and tagging each
// beat with a wrapping frame index on tuser.
// Ports:
//   clk, sync_reset     clock, synchronous active-high reset
//   frame_len           beats per frame minus 1, sampled at beat 0 of a frame
//   fifo_empty          native FIFO empty flag
//   fifo_rd_en          native FIFO read strobe (combinational)
//   fifo_dout           FIFO read data, valid the cycle after fifo_rd_en
//   m_axis_*            AXI-stream master (tlast is combinational on state)
//   frame_done          one-cycle pulse the cycle after the tlast handshake
// -----------------------------------------------------------------------------
module axis_fifo_reader #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned TUSER_WIDTH = 8,
   parameter int unsigned LEN_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   sync_reset,
   input  logic [LEN_WIDTH-1:0]   frame_len,
   input  logic                   fifo_empty,
   output logic                   fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]  fifo_dout,
   output logic                   m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic [TUSER_WIDTH-1:0] m_axis_tuser,
   input  logic                   m_axis_tready,
   output logic                   frame_done
);

   localparam int unsigned      CNT_WIDTH    = 2;
   localparam logic [CNT_WIDTH-1:0] CREDIT_DEPTH = CNT_WIDTH'(2);

   logic [CNT_WIDTH-1:0]   cnt;
   logic [CNT_WIDTH-1:0]   cnt_after_pop;
   logic                   rd_pending;
   logic                   pop;
   logic [LEN_WIDTH-1:0]   beat_cnt;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   len_eff;
   logic [TUSER_WIDTH-1:0] frame_idx;

   assign pop = m_axis_tvalid & m_axis_tready;

   // Credit counts buffered words plus a read in flight; a slot freed by this
   // cycle's pop may be refilled by this cycle's read.
   assign cnt_after_pop = cnt - CNT_WIDTH'(pop);
   assign fifo_rd_en    = ~fifo_empty & ~sync_reset & (cnt_after_pop < CREDIT_DEPTH);

   // frame_len is live at beat 0 and frozen for the rest of the frame.
   assign len_eff      = (beat_cnt == '0) ? frame_len : len_q;
   assign m_axis_tlast = m_axis_tvalid & (beat_cnt == len_eff);
   assign m_axis_tuser = frame_idx;

   // Credit, read pipeline and framing state.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         cnt        <= '0;
         rd_pending <= 1'b0;
         beat_cnt   <= '0;
         len_q      <= '0;
         frame_idx  <= '0;
         frame_done <= 1'b0;
      end else begin
         cnt        <= cnt + CNT_WIDTH'(fifo_rd_en) - CNT_WIDTH'(pop);
         rd_pending <= fifo_rd_en;
         frame_done <= pop & m_axis_tlast;
         if (pop) begin
            if (beat_cnt == '0) len_q <= frame_len;
            if (m_axis_tlast) begin
               beat_cnt  <= '0;
               frame_idx <= frame_idx + TUSER_WIDTH'(1);
            end else begin
               beat_cnt  <= beat_cnt + LEN_WIDTH'(1);
            end
         end
      end
   end

   // Output buffer; the word read last cycle is captured from fifo_dout now.
   axis_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk        (clk),
      .sync_reset (sync_reset),
      .in_valid   (rd_pending),
      .in_data    (fifo_dout),
      .out_valid  (m_axis_tvalid),
      .out_data   (m_axis_tdata),
      .out_ready  (m_axis_tready)
   );

endmodule
